// File: rtl/lcd_pkg.sv
// lcd_pkg: RGB565 colours, pattern select and FSM state types shared by the LCD pixel path.
package lcd_pkg;

    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;

    typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECK, PAT_GRAD} pattern_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} state_e;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pixel_source_if.sv
// lcd_pixel_source_if: valid/ready RGB565 pixel stream with frame/line markers.
//   master: drives pix_valid, pix_data, pix_sof, pix_eol, pix_eof; samples pix_ready
//   slave : samples the stream; drives pix_ready
interface lcd_pixel_source_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/lcd_pattern_lut.sv
// lcd_pattern_lut: combinational test-pattern colour generator.
//   pattern     : selected pattern
//   x_cell      : x[7:3] of the pixel (8-pixel column cell / gradient level)
//   y_cell      : y[3] of the pixel (8-line row cell parity)
//   bar_idx     : colour-bar index of the pixel
//   solid_color : colour for the solid pattern
//   rgb         : RGB565 result
module lcd_pattern_lut
    import lcd_pkg::*;
(
    input  pattern_e    pattern,
    input  logic [4:0]  x_cell,
    input  logic        y_cell,
    input  logic [2:0]  bar_idx,
    input  logic [15:0] solid_color,
    output logic [15:0] rgb
);
    always_comb
        rgb = (pattern == PAT_SOLID) ? solid_color :
              (pattern == PAT_BARS)  ? bar_color(bar_idx) :
              (pattern == PAT_CHECK) ? ((x_cell[0] ^ y_cell) ? C_BLACK : C_WHITE) :
                                       {x_cell, 11'b0};
endmodule

// File: rtl/lcd_pixel_source.sv
// lcd_pixel_source: emits one frame of a selectable test pattern per start request.
//   clk, resetn             : clock, asynchronous active-low reset
//   start, abort            : one-cycle frame request / frame drop
//   pattern, solid_color    : pattern select and solid colour, latched at start
//   pix (master)            : pixel stream to the LCD writer
//   busy, frame_done        : frame in progress / one-cycle end-of-frame pulse
module lcd_pixel_source
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 240,
    parameter int V_ACTIVE = 135,
    parameter int BAR_W    = 30
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         pattern,
    input  logic [15:0]        solid_color,
    lcd_pixel_source_if.master pix,
    output logic               busy,
    output logic               frame_done
);
    localparam logic [8:0] X_LAST   = 9'(H_ACTIVE - 1);
    localparam logic [7:0] Y_LAST   = 8'(V_ACTIVE - 1);
    localparam logic [8:0] BAR_LAST = 9'(BAR_W - 1);

    state_e      state_q, state_d;
    pattern_e    pattern_q, pattern_d;
    logic [15:0] color_q, color_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [8:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        pix_sof_q, pix_sof_d;
    logic        pix_eol_q, pix_eol_d;
    logic        pix_eof_q, pix_eof_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        xfer, nxt_sof, nxt_eol, nxt_eof;
    logic [15:0] rgb;

    assign xfer    = pix_valid_q && pix.pix_ready;
    assign nxt_sof = (x_d == '0) && (y_d == '0);
    assign nxt_eol = (x_d == X_LAST);
    assign nxt_eof = nxt_eol && (y_d == Y_LAST);

    // Coordinates of the pixel to be presented next; the LUT colours that pixel
    // so pix_data is always registered one step ahead of the counters.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (state_q == ST_IDLE && start) begin
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (state_q == ST_STREAM && xfer && !pix_eof_q) begin
            if (x_q == X_LAST) begin
                x_d       = '0;
                y_d       = y_q + 8'd1;
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else begin
                x_d       = x_q + 9'd1;
                bar_cnt_d = (bar_cnt_q == BAR_LAST) ? '0 : bar_cnt_q + 9'd1;
                bar_idx_d = (bar_cnt_q == BAR_LAST) ? bar_idx_q + 3'd1 : bar_idx_q;
            end
        end
    end

    lcd_pattern_lut u_lut (
        .pattern     (pattern_q),
        .x_cell      (x_d[7:3]),
        .y_cell      (y_d[3]),
        .bar_idx     (bar_idx_d),
        .solid_color (color_q),
        .rgb         (rgb)
    );

    always_comb begin
        state_d      = state_q;
        pattern_d    = pattern_q;
        color_d      = color_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        pix_sof_d    = pix_sof_q;
        pix_eol_d    = pix_eol_q;
        pix_eof_d    = pix_eof_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_LOAD;
                pattern_d = pattern_e'(pattern);
                color_d   = solid_color;
                busy_d    = 1'b1;
            end
            ST_LOAD: begin
                state_d     = ST_STREAM;
                pix_valid_d = 1'b1;
                pix_data_d  = rgb;
                pix_sof_d   = nxt_sof;
                pix_eol_d   = nxt_eol;
                pix_eof_d   = nxt_eof;
            end
            ST_STREAM: if (xfer) begin
                if (pix_eof_q) begin
                    state_d      = ST_IDLE;
                    pix_valid_d  = 1'b0;
                    pix_sof_d    = 1'b0;
                    pix_eol_d    = 1'b0;
                    pix_eof_d    = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    pix_data_d = rgb;
                    pix_sof_d  = nxt_sof;
                    pix_eol_d  = nxt_eol;
                    pix_eof_d  = nxt_eof;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_d      = ST_IDLE;
            pix_valid_d  = 1'b0;
            pix_sof_d    = 1'b0;
            pix_eol_d    = 1'b0;
            pix_eof_d    = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pattern_q    <= PAT_SOLID;
            color_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_eof_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            color_q      <= color_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bar_cnt_q    <= bar_cnt_d;
            bar_idx_q    <= bar_idx_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_sof_q    <= pix_sof_d;
            pix_eol_q    <= pix_eol_d;
            pix_eof_q    <= pix_eof_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_data  = pix_data_q;
    assign pix.pix_sof   = pix_sof_q;
    assign pix.pix_eol   = pix_eol_q;
    assign pix.pix_eof   = pix_eof_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_lcd_pixel_source.sv
// tb_lcd_pixel_source: directed self-checking bench for lcd_pixel_source.
`timescale 1ns/1ps
module tb_lcd_pixel_source;
    localparam int H = 240;
    localparam int V = 16;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        busy;
    logic        frame_done;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cap [N];

    lcd_pixel_source_if pix();

    lcd_pixel_source #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(30)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .solid_color (solid_color),
        .pix         (pix),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #18 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int pat, input int x, input int y, input logic [15:0] col);
        case (pat)
            0: return col;
            1: case (x / 30)
                0: return 16'hFFFF;
                1: return 16'hFFE0;
                2: return 16'h07FF;
                3: return 16'h07E0;
                4: return 16'hF81F;
                5: return 16'hF800;
                6: return 16'h001F;
                default: return 16'h0000;
            endcase
            2: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'h0000 : 16'hFFFF;
            default: return 16'(((x >> 3) & 31) << 11);
        endcase
    endfunction

    // Starts a frame and consumes up to 'limit' pixels, checking every pixel,
    // flag and stall-hold against the model; full frames also check the end.
    task automatic run_frame(input int pat, input logic [15:0] col, input bit rnd, input int limit);
        int idx = 0, cyc = 0, bad = 0, gaps = 0, eols = 0, dones = 0, x, y;
        bit r, stalled = 0;
        logic [15:0] pd = '0;
        logic [2:0] pf = '0;
        pix.pix_ready = 1'b0;
        pattern = 2'(pat);
        solid_color = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern = 2'(pat + 1);
        solid_color = ~col;
        chk("busy_after_start", 32'(busy), 1);
        chk("no_valid_in_load", 32'(pix.pix_valid), 0);
        @(negedge clk);
        chk("first_valid", 32'(pix.pix_valid), 1);
        chk("first_sof", 32'(pix.pix_sof), 1);
        while (idx < limit && cyc < 4 * N) begin
            if (stalled && (pix.pix_data !== pd || {pix.pix_sof, pix.pix_eol, pix.pix_eof} !== pf
                            || pix.pix_valid !== 1'b1)) bad++;
            if (frame_done !== 1'b0) dones++;
            start = (cyc == 50);
            if (pix.pix_valid !== 1'b1) gaps++;
            else begin
                x = idx % H;
                y = idx / H;
                if (pix.pix_data !== exp_pix(pat, x, y, col)) bad++;
                if ({pix.pix_sof, pix.pix_eol, pix.pix_eof} !== {idx == 0, x == H - 1, idx == N - 1}) bad++;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pix.pix_ready = r;
            stalled = pix.pix_valid && !r;
            pd = pix.pix_data;
            pf = {pix.pix_sof, pix.pix_eol, pix.pix_eof};
            if (pix.pix_valid && r) begin
                cap[idx] = pix.pix_data;
                if (pix.pix_eol) eols++;
                if (idx == N - 1) start = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("transfer_count", 32'(idx), 32'(limit));
        chk("no_gaps", 32'(gaps), 0);
        chk("pixel_errors", 32'(bad), 0);
        chk("no_early_done", 32'(dones), 0);
        if (limit == N) begin
            chk("eol_count", 32'(eols), 32'(V));
            chk("end_valid_low", 32'(pix.pix_valid), 0);
            chk("end_busy_low", 32'(busy), 0);
            chk("done_pulse", 32'(frame_done), 1);
            start = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", 32'(frame_done), 0);
            chk("start_at_eof_ignored", 32'(busy), 0);
        end
        start = 1'b0;
    endtask

    initial begin
        pix.pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pix.pix_valid), 0);
        chk("rst_data", 32'(pix.pix_data), 0);
        chk("rst_flags", 32'({pix.pix_sof, pix.pix_eol, pix.pix_eof}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(busy), 0);

        run_frame(1, 16'h1234, 1'b0, N);
        chk("bars_px0", 32'(cap[0]), 32'hFFFF);
        chk("bars_px29", 32'(cap[29]), 32'hFFFF);
        chk("bars_px30", 32'(cap[30]), 32'hFFE0);
        chk("bars_px59", 32'(cap[59]), 32'hFFE0);
        chk("bars_px210", 32'(cap[210]), 32'h0000);
        chk("bars_px239", 32'(cap[239]), 32'h0000);
        chk("bars_line1_px0", 32'(cap[240]), 32'hFFFF);

        run_frame(0, 16'h001F, 1'b1, N);
        chk("solid_px1234", 32'(cap[1234]), 32'h001F);

        run_frame(2, 16'h0000, 1'b0, N);
        chk("check_8_0", 32'(cap[8]), 32'h0000);
        chk("check_8_8", 32'(cap[8 * H + 8]), 32'hFFFF);
        chk("check_0_0", 32'(cap[0]), 32'hFFFF);

        run_frame(3, 16'h0000, 1'b0, N);
        chk("grad_0_3", 32'(cap[3 * H]), 32'h0000);
        chk("grad_8_3", 32'(cap[3 * H + 8]), 32'h0800);
        chk("grad_239_3", 32'(cap[3 * H + 239]), 32'hE800);

        run_frame(1, 16'h0000, 1'b0, 1000);
        pix.pix_ready = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", 32'(pix.pix_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_flags", 32'({pix.pix_sof, pix.pix_eol, pix.pix_eof}), 0);
        chk("abort_no_done", 32'(frame_done), 0);
        @(negedge clk);
        chk("abort_beats_start", 32'(busy), 0);
        chk("abort_no_done_later", 32'(frame_done), 0);
        run_frame(0, 16'hA5A5, 1'b0, N);

        run_frame(2, 16'h0000, 1'b1, 500);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(pix.pix_valid), 0);
        chk("midrst_data", 32'(pix.pix_data), 0);
        chk("midrst_flags", 32'({pix.pix_sof, pix.pix_eol, pix.pix_eof}), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(frame_done), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("release_no_done", 32'(frame_done), 0);
        chk("release_idle", 32'(busy), 0);
        run_frame(3, 16'h0000, 1'b0, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_pixel_source.md
LCD_PIXEL_SOURCE -- requirements
Module: lcd_pixel_source

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 240, meaning pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 135, meaning lines per frame (H_ACTIVE*V_ACTIVE = 32400).
REQ-003 SHALL have parameter BAR_W, default 30, meaning colour-bar width in pixels (H_ACTIVE/8).
REQ-004 clk  input  1  system clock, 27 MHz; all logic on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to emit one frame.
REQ-007 abort  input  1  single-cycle request to drop the current frame.
REQ-008 pattern  input  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 red gradient.
REQ-009 solid_color  input  16  RGB565 colour for pattern 0.
REQ-010 pix_valid  output  1  pix_data holds a valid pixel.
REQ-011 pix_ready  input  1  downstream SPI LCD writer accepts the pixel.
REQ-012 pix_data  output  16  RGB565 pixel, MSB byte sent first downstream.
REQ-013 pix_sof / pix_eol / pix_eof  output  1 each  first pixel of frame / last pixel of line / last pixel of frame.
REQ-014 busy  output  1  high from start acceptance until frame end or abort.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel transfer.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> STREAM -> IDLE; transfer = pix_valid && pix_ready at a rising edge.
REQ-017 IDLE: start=1 latches pattern and solid_color, clears x=0, y=0, bar counters; moves to LOAD; busy=1 next cycle.
REQ-018 LOAD: registers pixel (0,0) into pix_data with pix_sof=1, sets pix_valid=1, moves to STREAM; first valid exactly 2 cycles after start.
REQ-019 STREAM: on each transfer, advance x; at x=H_ACTIVE-1 wrap x to 0 and increment y; register next pixel so pix_valid stays 1 with zero bubbles while pix_ready=1.
REQ-020 pix_valid=1 and pix_ready=0: pix_data and all flags SHALL hold unchanged.
REQ-021 pix_eol=1 when x=H_ACTIVE-1; pix_eof=1 only at x=H_ACTIVE-1, y=V_ACTIVE-1; pix_sof=1 only at (0,0).
REQ-022 Transfer of the pix_eof pixel: pix_valid=0, busy=0, frame_done=1 for one cycle, return to IDLE.
REQ-023 Pattern 0: every pixel = latched solid_color.
REQ-024 Pattern 1: bar index = x/BAR_W via counter (no divider); bars 0..7 = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-025 Pattern 2: FFFF when x[3]^y[3]=0, else 0000 (8x8 cells).
REQ-026 Pattern 3: R = x[7:3] (5 bits), G=0, B=0, i.e. {x[7:3], 11'b0}.
REQ-027 x counter 9 bits, y counter 8 bits; no overflow for default parameters.
REQ-028 start while busy=1 SHALL be ignored; pattern/solid_color changes mid-frame SHALL NOT affect the frame.
REQ-029 abort in any state: next cycle pix_valid=0, flags=0, busy=0, no frame_done, state IDLE; abort wins over simultaneous start.
REQ-030 start and transfer of pix_eof in the same cycle: start ignored (busy still 1); a new start is needed after frame_done.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, x=y=0, pix_valid=0, pix_data=0000, pix_sof=pix_eol=pix_eof=0, busy=0, frame_done=0.
REQ-032 Reset mid-frame SHALL discard the frame; no frame_done on release.

Structure
REQ-033 Package lcd_pkg SHALL hold the RGB565 colour constants, the pattern enumeration and the FSM state typedef, shared with the SPI LCD writer.
REQ-034 Sub-module lcd_pattern_lut (combinational: pattern, x, y, bar index, solid colour -> RGB565) SHALL be the only sub-module.

Verification
REQ-035 pattern=1, pix_ready=1, start pulse -> 32400 transfers, no gaps; pixels 0-29 FFFF, 30-59 FFE0, 210-239 0000; eol every 240; frame_done once.
REQ-036 pattern=0, solid_color=001F, pix_ready toggling randomly -> every pixel 001F, data/flags stable while stalled, count 32400.
REQ-037 pattern=2 -> pixel (8,0)=0000, (8,8)=FFFF, (0,0)=FFFF with pix_sof=1.
REQ-038 pattern=3 -> pixel (0,y)=0000, (8,y)=0800, (239,y)=E800.
REQ-039 Abort at pixel 1000 then start pattern=0 -> pix_valid low 1 cycle after abort; new frame starts with pix_sof=1, full 32400 pixels.
REQ-040 resetn low at pixel 500 -> all outputs reset immediately; start after release yields complete frame; start while busy ignored.
